ingress_multi_channel_packetizer: RTL
=====================================

# ingress_multi_channel_packetizer

Multi-channel successor to the single-channel ingress packetizer. It accepts payload words from C_NUM_CHANNELS independent valid/ready ingress channels and picks one per cycle by round-robin arbitration. Each accepted word gets a routing/source header and is buffered in a C_FIFO_DEPTH-entry packet FIFO feeding the layer-engine NoC egress port. It adds broadcast and drop modes plus a saturating drop counter.

## Interface
- C_NUM_CHANNELS, 4, ingress channel count (1..16)
- C_PACKET_PAYLOAD_WIDTH, 128, payload bits per channel
- C_PACKET_HEADER_WIDTH, 16, header bits (fixed layout below)
- C_PACKET_WIDTH, C_PACKET_PAYLOAD_WIDTH + C_PACKET_HEADER_WIDTH, egress word width
- C_FIFO_DEPTH, 4, packet FIFO entries (power of 2, ≥2)
- C_MATCH_ID_HIGH, 127, MSB of the 6-bit model-ID field in the payload (route-match mode)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  2  00 route-match, 01 option-route, 10 broadcast, 11 drop
- option  in  8  option[5:0] = destination PE in option-route mode
- ingress_valid  in  C_NUM_CHANNELS  per-channel valid
- ingress_ready  out  C_NUM_CHANNELS  per-channel ready (one-hot or zero)
- ingress_data  in  C_NUM_CHANNELS*C_PACKET_PAYLOAD_WIDTH  channel i at slice [i*W +: W]
- egress_valid  out  1  FIFO head valid
- egress_ready  in  1  downstream accept
- egress_data  out  C_PACKET_WIDTH  {header, payload}, payload in LSBs
- fifo_count  out  $clog2(C_FIFO_DEPTH)+1  occupancy
- drop_count  out  16  saturating count of words discarded in drop mode

## Operation
- Header: [15:12] source channel index; [11:0] destination. Route-match: {6'b0, payload[C_MATCH_ID_HIGH -: 6]}. Option-route: {6'b0, option[5:0]}. Broadcast: 12'hFFF.
- Arbiter: rr_ptr (channel index). The grant goes to the first channel with valid set, searching from rr_ptr upward and wrapping. After a grant, rr_ptr <= granted + 1 mod C_NUM_CHANNELS. With no grant, rr_ptr holds.
- Space condition: fifo_count < C_FIFO_DEPTH, or (full and egress_valid & egress_ready) in the same cycle.
- ingress_ready[g] = 1 for the granted channel only, and only when the space condition holds. In drop mode space is ignored. ready may depend combinationally on valid and on egress_ready.
- Accept (valid & ready), modes 00/01/10: push {header, payload} into the FIFO.
- Accept, mode 11: no push. drop_count increments and saturates at 16'hFFFF.
- mode and option are sampled at the accept cycle. Mode changes take effect on the next accept; words already in the FIFO are unaffected.
- Egress: egress_valid = fifo_count != 0. Pop on egress_valid & egress_ready. egress_data is stable while valid and not ready.
- Push and pop in the same cycle leave fifo_count unchanged, including at full and at count 1.

## Timing
- Reset values: egress_valid 0, egress_data 0, ingress_ready all 0 while rst is high, fifo_count 0, drop_count 0, rr_ptr 0.
- Reset mid-operation discards FIFO contents and returns every output to its reset value on the next edge.
- Latency: accept at cycle T into an empty FIFO gives egress_valid=1 with that packet at T+1.
- Throughput: one packet per cycle sustained when egress_ready is held high.
- Full with no pop: all ready low, except that drop mode still accepts.

## Structure
- In cnn_layer_accel_defines.vh: mode encodings (PACKETIZER_MODE_ROUTE_MATCH, _ROUTE_OPTION, _BROADCAST, _DROP), header field macros (PACKET_HEADER_SRC_FIELD, PACKET_HEADER_DEST_FIELD, PACKET_PAYLOAD_FIELD), and the broadcast address constant.
- Sub-module: packet_fifo, a synchronous FIFO parameterised by width and depth, with a registered head and a count output. The arbiter stays inline.

## Test plan
- Single channel, mode 01, option=6'h2A, payload 128'h1: egress_data header = 16'h002A (channel 0) one cycle after accept; fifo_count returns to 0.
- All 4 channels valid continuously, egress_ready=1: grants rotate 0,1,2,3,0; source fields follow that order; one packet per cycle.
- egress_ready=0 with 5 words offered: 4 are accepted, fifo_count=4, ready goes low. Raising egress_ready and pushing on the same cycle keeps count at 4, and the pop order is FIFO.
- Mode 00, payload[127:122]=6'h15: destination 12'h015. Mode 10: destination 12'hFFF.
- Mode 11 with the FIFO full: channel still accepted, drop_count increments, no push. Pre-loaded at 16'hFFFF, drop_count holds after a further drop.
- rst asserted with 3 words buffered: next cycle egress_valid=0, fifo_count=0, drop_count=0; first grant after reset goes to channel 0.

Source files
------------

// File: rtl/ingress_multi_channel_packetizer_pkg.sv
// Shared definitions for the multi-channel ingress packetizer: default
// geometry, mode encodings, the header layout and the destination rule.
package ingress_multi_channel_packetizer_pkg;

    localparam int DEF_NUM_CHANNELS       = 4;
    localparam int DEF_PACKET_PAYLOAD_W   = 128;
    localparam int DEF_PACKET_HEADER_W    = 16;
    localparam int DEF_FIFO_DEPTH         = 4;
    localparam int DEF_MATCH_ID_HIGH      = 127;

    localparam int HDR_SRC_WIDTH          = 4;
    localparam int HDR_DEST_WIDTH         = 12;
    localparam int MATCH_ID_WIDTH         = 6;

    localparam logic [HDR_DEST_WIDTH-1:0] BROADCAST_ADDR = 12'hFFF;
    localparam logic [15:0]               DROP_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        MODE_ROUTE_MATCH  = 2'b00,
        MODE_ROUTE_OPTION = 2'b01,
        MODE_BROADCAST    = 2'b10,
        MODE_DROP         = 2'b11
    } packetizer_mode_e;

    // Header occupies the top 16 bits of an egress word; payload sits below it.
    typedef struct packed {
        logic [HDR_SRC_WIDTH-1:0]  src;
        logic [HDR_DEST_WIDTH-1:0] dest;
    } packet_header_t;

    // Destination field for a word accepted in the given mode.
    function automatic logic [HDR_DEST_WIDTH-1:0] dest_for_mode(
        input packetizer_mode_e          mode,
        input logic [5:0]                option_pe,
        input logic [MATCH_ID_WIDTH-1:0] match_id
    );
        case (mode)
            MODE_ROUTE_MATCH:  return {6'b0, match_id};
            MODE_ROUTE_OPTION: return {6'b0, option_pe};
            default:           return BROADCAST_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/ingress_multi_channel_packetizer_if.sv
// Bus bundle between the packetizer and its environment. The slave modport
// is the packetizer's view; master is the driving side.
//
// Handshake rule for every channel: a word moves on a rising edge where
// valid and ready are both high. Once raised, valid holds its word until
// accepted; ready may depend combinationally on valid (ingress) and on
// egress_ready, and egress_data is held stable while egress_valid is high
// and egress_ready is low.
interface ingress_multi_channel_packetizer_if
    import ingress_multi_channel_packetizer_pkg::*;
#(
    parameter int C_NUM_CHANNELS         = DEF_NUM_CHANNELS,
    parameter int C_PACKET_PAYLOAD_WIDTH = DEF_PACKET_PAYLOAD_W,
    parameter int C_PACKET_HEADER_WIDTH  = DEF_PACKET_HEADER_W,
    parameter int C_PACKET_WIDTH         = C_PACKET_PAYLOAD_WIDTH + C_PACKET_HEADER_WIDTH,
    parameter int C_FIFO_DEPTH           = DEF_FIFO_DEPTH
);
    logic [1:0]                                       mode;
    logic [7:0]                                       option;
    logic [C_NUM_CHANNELS-1:0]                        ingress_valid;
    logic [C_NUM_CHANNELS-1:0]                        ingress_ready;
    logic [C_NUM_CHANNELS*C_PACKET_PAYLOAD_WIDTH-1:0] ingress_data;
    logic                                             egress_valid;
    logic                                             egress_ready;
    logic [C_PACKET_WIDTH-1:0]                        egress_data;
    logic [$clog2(C_FIFO_DEPTH):0]                    fifo_count;
    logic [15:0]                                      drop_count;
    logic [3:0]                                       dbg_rr_ptr;

    modport slave (
        input  mode, option, ingress_valid, ingress_data, egress_ready,
        output ingress_ready, egress_valid, egress_data, fifo_count, drop_count, dbg_rr_ptr
    );

    modport master (
        output mode, option, ingress_valid, ingress_data, egress_ready,
        input  ingress_ready, egress_valid, egress_data, fifo_count, drop_count, dbg_rr_ptr
    );
endinterface

// File: rtl/ingress_multi_channel_packetizer_packet_fifo.sv
// Shift-style packet FIFO: entry 0 is always the head, so the egress word
// comes straight from a flop and stays put while the consumer stalls.
module packet_fifo #(
    parameter int C_WIDTH = 144,
    parameter int C_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [C_WIDTH-1:0]       i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [C_WIDTH-1:0]       o_data,
    output logic [$clog2(C_DEPTH):0] o_count
);
    localparam int CNT_W = $clog2(C_DEPTH) + 1;

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;
    logic [CNT_W-1:0]   w_wr_idx;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(C_DEPTH)) || w_do_pop);
    // A simultaneous pop shifts everything down, so the new word lands one lower.
    assign w_wr_idx  = r_count - CNT_W'(w_do_pop);

    // Storage shift on pop, tail write on push, occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                for (int i = 0; i < C_DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (w_do_push) begin
                for (int i = 0; i < C_DEPTH; i++) begin
                    if (CNT_W'(i) == w_wr_idx) begin
                        r_mem[i] <= i_data;
                    end
                end
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CNT_W'(C_DEPTH));
    assign o_data  = r_mem[0];
    assign o_count = r_count;

endmodule

// File: rtl/ingress_multi_channel_packetizer.sv
// Multi-channel ingress packetizer: round-robin pick of one ingress word per
// cycle, header insertion (route-match / option-route / broadcast), or
// counted discard in drop mode, feeding a small packet FIFO to the NoC.
module ingress_multi_channel_packetizer
    import ingress_multi_channel_packetizer_pkg::*;
#(
    parameter int C_NUM_CHANNELS         = DEF_NUM_CHANNELS,
    parameter int C_PACKET_PAYLOAD_WIDTH = DEF_PACKET_PAYLOAD_W,
    parameter int C_PACKET_HEADER_WIDTH  = DEF_PACKET_HEADER_W,
    parameter int C_PACKET_WIDTH         = C_PACKET_PAYLOAD_WIDTH + C_PACKET_HEADER_WIDTH,
    parameter int C_FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int C_MATCH_ID_HIGH        = DEF_MATCH_ID_HIGH
) (
    input logic                               clk,
    input logic                               rst,
    ingress_multi_channel_packetizer_if.slave bus
);
    localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
    localparam int W     = C_PACKET_PAYLOAD_WIDTH;

    logic [3:0]                r_rr_ptr;
    logic [15:0]               r_drop_count;

    packetizer_mode_e          w_mode;
    logic                      w_grant_found;
    logic [3:0]                w_grant_idx;
    logic [W-1:0]              w_grant_data;
    packet_header_t            w_header;
    logic [C_PACKET_WIDTH-1:0] w_fifo_din;
    logic [C_NUM_CHANNELS-1:0] w_ready;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_space;
    logic                      w_fifo_valid;
    logic                      w_fifo_full;
    logic [C_PACKET_WIDTH-1:0] w_fifo_head;
    logic [CNT_W-1:0]          w_fifo_count;
    logic [1:0]                w_unused;

    assign w_mode   = packetizer_mode_e'(bus.mode);
    assign w_unused = bus.option[7:6];

    // Round-robin search: first valid at or above rr_ptr, else first valid below it.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int j = 0; j < C_NUM_CHANNELS; j++) begin
            if (!w_grant_found && bus.ingress_valid[j] && (4'(j) >= r_rr_ptr)) begin
                w_grant_found = 1'b1;
                w_grant_idx   = 4'(j);
            end
        end
        for (int j = 0; j < C_NUM_CHANNELS; j++) begin
            if (!w_grant_found && bus.ingress_valid[j]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = 4'(j);
            end
        end
    end

    // Payload mux for the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int j = 0; j < C_NUM_CHANNELS; j++) begin
            if (4'(j) == w_grant_idx) begin
                w_grant_data = bus.ingress_data[j*W +: W];
            end
        end
    end

    assign w_header.src  = w_grant_idx;
    assign w_header.dest = dest_for_mode(w_mode, bus.option[5:0],
                                         w_grant_data[C_MATCH_ID_HIGH -: MATCH_ID_WIDTH]);
    assign w_fifo_din    = {w_header, w_grant_data};

    // A full FIFO still has room this cycle if its head leaves on the same edge.
    assign w_pop   = w_fifo_valid && bus.egress_ready;
    assign w_space = !w_fifo_full || w_pop;

    // Ready only to the granted channel; drop mode never needs FIFO room.
    always_comb begin
        w_ready = '0;
        for (int j = 0; j < C_NUM_CHANNELS; j++) begin
            w_ready[j] = !rst && w_grant_found && (4'(j) == w_grant_idx)
                         && ((w_mode == MODE_DROP) || w_space);
        end
    end

    assign w_accept = |(w_ready & bus.ingress_valid);
    assign w_push   = w_accept && (w_mode != MODE_DROP);

    // Pointer moves past the winner after each accept; holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_idx == 4'(C_NUM_CHANNELS - 1)) ? 4'd0 : w_grant_idx + 4'd1;
        end
    end

    // Saturating count of words swallowed in drop mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_accept && (w_mode == MODE_DROP) && (r_drop_count != DROP_COUNT_MAX)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    packet_fifo #(
        .C_WIDTH (C_PACKET_WIDTH),
        .C_DEPTH (C_FIFO_DEPTH)
    ) u_packet_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign bus.ingress_ready = w_ready;
    assign bus.egress_valid  = w_fifo_valid;
    assign bus.egress_data   = w_fifo_head;
    assign bus.fifo_count    = w_fifo_count;
    assign bus.drop_count    = r_drop_count;
    assign bus.dbg_rr_ptr    = r_rr_ptr;

endmodule
